// File: rtl/half_adder_pkg.sv
// half_adder_pkg: shared constants and lane type for the half adder cell
package half_adder_pkg;
    localparam int HA_DEFAULT_WIDTH = 1;
    localparam int HA_MAX_WIDTH = 64;
    typedef struct packed {
        logic result;
        logic carry;
    } ha_lane_t;
endpackage

// File: rtl/half_adder_unit_if.sv
// half_adder_unit_if: operand/result bundle between a producer and the half adder
interface half_adder_unit_if #(
    parameter int WIDTH = 1
);
    logic             i_valid;
    logic [WIDTH-1:0] i_operand1;
    logic [WIDTH-1:0] i_operand2;
    logic             o_valid;
    logic [WIDTH-1:0] o_result;
    logic [WIDTH-1:0] o_carry;
    modport master (output i_valid, i_operand1, i_operand2, input o_valid, o_result, o_carry);
    modport slave  (input i_valid, i_operand1, i_operand2, output o_valid, o_result, o_carry);
endinterface

// File: rtl/half_adder_bit.sv
// half_adder_bit: single-lane combinational half adder cell
module half_adder_bit (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum = i_a ^ i_b;
    assign o_carry = i_a & i_b;
endmodule

// File: rtl/half_adder_unit.sv
// half_adder_unit: WIDTH independent half-adder lanes with optional output register stage
module half_adder_unit
    import half_adder_pkg::*;
#(
    parameter int WIDTH = HA_DEFAULT_WIDTH,
    parameter bit REGISTERED = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    half_adder_unit_if.slave bus
);
    ha_lane_t [WIDTH-1:0] w_lane;
    ha_lane_t [WIDTH-1:0] w_out;
    logic                 w_valid;
    if (WIDTH < 1 || WIDTH > HA_MAX_WIDTH) begin : g_bad_width
        $error("half_adder_unit: WIDTH %0d outside 1..%0d", WIDTH, HA_MAX_WIDTH);
    end
    for (genvar k = 0; k < WIDTH; k++) begin : g_lane
        half_adder_bit u_bit (
            .i_a     (bus.i_operand1[k]),
            .i_b     (bus.i_operand2[k]),
            .o_sum   (w_lane[k].result),
            .o_carry (w_lane[k].carry)
        );
    end
    if (REGISTERED) begin : g_reg
        ha_lane_t [WIDTH-1:0] r_lane;
        logic                 r_valid;
        // results hold across idle cycles; only o_valid drops
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_lane  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= bus.i_valid;
                if (bus.i_valid) r_lane <= w_lane;
            end
        end
        assign w_out = r_lane;
        assign w_valid = r_valid;
    end else begin : g_comb
        assign w_out = w_lane;
        assign w_valid = bus.i_valid;
    end
    always_comb begin
        bus.o_result = '0;
        bus.o_carry = '0;
        for (int k = 0; k < WIDTH; k++) begin
            bus.o_result[k] = w_out[k].result;
            bus.o_carry[k] = w_out[k].carry;
        end
    end
    assign bus.o_valid = w_valid;
endmodule

// File: tb/tb_half_adder_unit.sv
// tb_half_adder_unit: directed scoreboard bench for registered, multi-lane and bypass configurations
module tb_half_adder_unit;
    typedef struct {
        logic [3:0] r;
        logic [3:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    half_adder_unit_if #(.WIDTH(1)) b1 ();
    half_adder_unit_if #(.WIDTH(4)) b4 ();
    half_adder_unit_if #(.WIDTH(1)) bc ();

    half_adder_unit #(.WIDTH(1), .REGISTERED(1'b1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(b1));
    half_adder_unit #(.WIDTH(4), .REGISTERED(1'b1)) dut4 (.i_clk(clk), .i_rst(rst), .bus(b4));
    half_adder_unit #(.WIDTH(1), .REGISTERED(1'b0)) dutc (.i_clk(clk), .i_rst(rst), .bus(bc));

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input int w);
        exp_t x;
        logic [1:0] s;
        x.r = '0;
        x.c = '0;
        for (int k = 0; k < w; k++) begin
            s = {1'b0, a[k]} + {1'b0, b[k]};
            x.r[k] = s[0];
            x.c[k] = s[1];
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b1.i_valid = 1'b1;
        b1.i_operand1 = 1'b1;
        b1.i_operand2 = 1'b1;
        b4.i_valid = 1'b1;
        b4.i_operand1 = 4'hf;
        b4.i_operand2 = 4'hf;
        bc.i_valid = 1'b0;
        bc.i_operand1 = 1'b0;
        bc.i_operand2 = 1'b0;
        repeat (2) step();
        check("rst_result", 4'(b1.o_result), 4'h0);
        check("rst_carry", 4'(b1.o_carry), 4'h0);
        check("rst_valid", 4'(b1.o_valid), 4'h0);
        check("rst_valid4", 4'(b4.o_valid), 4'h0);
        check("rst_carry4", b4.o_carry, 4'h0);
        rst = 1'b0;
        b4.i_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b1.i_operand1 = i[1];
            b1.i_operand2 = i[0];
            b1.i_valid = 1'b1;
            sb.push_back(model(4'(i[1]), 4'(i[0]), 1));
            step();
            e = sb.pop_front();
            check($sformatf("tt%0d_result", i), 4'(b1.o_result), e.r);
            check($sformatf("tt%0d_carry", i), 4'(b1.o_carry), e.c);
            check($sformatf("tt%0d_valid", i), 4'(b1.o_valid), 4'h1);
        end
        b1.i_operand1 = 1'b1;
        b1.i_operand2 = 1'b1;
        sb.push_back(model(4'h1, 4'h1, 1));
        step();
        e = sb.pop_front();
        check("hold_pre_carry", 4'(b1.o_carry), e.c);
        b1.i_valid = 1'b0;
        b1.i_operand1 = 1'b0;
        b1.i_operand2 = 1'b1;
        repeat (2) step();
        check("hold_result", 4'(b1.o_result), 4'h0);
        check("hold_carry", 4'(b1.o_carry), 4'h1);
        check("hold_valid", 4'(b1.o_valid), 4'h0);
        b4.i_valid = 1'b1;
        b4.i_operand1 = 4'b1100;
        b4.i_operand2 = 4'b1010;
        sb.push_back(model(4'b1100, 4'b1010, 4));
        step();
        e = sb.pop_front();
        check("lane4_result", b4.o_result, e.r);
        check("lane4_carry", b4.o_carry, e.c);
        check("lane4_const_result", b4.o_result, 4'b0110);
        check("lane4_const_carry", b4.o_carry, 4'b1000);
        for (int i = 0; i < 8; i++) begin
            b4.i_operand1 = 4'($urandom_range(0, 15));
            b4.i_operand2 = 4'($urandom_range(0, 15));
            sb.push_back(model(b4.i_operand1, b4.i_operand2, 4));
            step();
            e = sb.pop_front();
            check($sformatf("rand%0d_result", i), b4.o_result, e.r);
            check($sformatf("rand%0d_carry", i), b4.o_carry, e.c);
            check($sformatf("rand%0d_valid", i), 4'(b4.o_valid), 4'h1);
        end
        b4.i_valid = 1'b0;
        rst = 1'b1;
        b1.i_valid = 1'b1;
        b1.i_operand1 = 1'b1;
        b1.i_operand2 = 1'b0;
        step();
        check("prio_result", 4'(b1.o_result), 4'h0);
        check("prio_carry", 4'(b1.o_carry), 4'h0);
        check("prio_valid", 4'(b1.o_valid), 4'h0);
        rst = 1'b0;
        sb.push_back(model(4'h1, 4'h0, 1));
        step();
        e = sb.pop_front();
        check("post_rst_result", 4'(b1.o_result), e.r);
        check("post_rst_valid", 4'(b1.o_valid), 4'h1);
        b1.i_valid = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) begin
            bc.i_operand1 = i[1];
            bc.i_operand2 = i[0];
            bc.i_valid = i[0];
            sb.push_back(model(4'(i[1]), 4'(i[0]), 1));
            #1;
            e = sb.pop_front();
            check($sformatf("comb%0d_result", i), 4'(bc.o_result), e.r);
            check($sformatf("comb%0d_carry", i), 4'(bc.o_carry), e.c);
            check($sformatf("comb%0d_valid", i), 4'(bc.o_valid), 4'(i[0]));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
